// File: rtl/axil_master_bridge_pkg.sv
// Shared types for the AXI4-Lite master bridge: response codes, FSM states,
// default bus widths.
// Imported by the bus interface and by the bridge itself.
package axil_pkg;

    localparam int AXIL_ADDR_WIDTH = 16;
    localparam int AXIL_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_e;

endpackage

// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
// Ports: master drives aw*/w*/ar* payload+valid and bready/rready;
//        slave drives the readies, B response and R data/response.
interface axil_master_bridge_if
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );
endinterface

// File: rtl/axil_master_bridge.sv
// Purpose: single-beat cmd/rsp to AXI4-Lite master, one transaction in flight.
// Latency: accept N -> AXI valid N+1 -> bready/rready N+2 -> rsp_valid N+3.
// Backpressure: any slave stall or rsp_ready=0 holds the current state; cmd_ready=0 outside IDLE.
// Ports: clk/rst (sync, active-high); cmd_* request in; rsp_* response out;
//        m_axil master modport of axil_master_bridge_if.
// Optional: AXIL_MASTER_TIMEOUT_EN adds TIMEOUT_CYCLES and a sticky timeout_err output.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
`ifdef AXIL_MASTER_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    axil_master_bridge_if.master  m_axil
);

    state_e                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [2:0]            prot_q, prot_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  aw_hs, w_hs;

    // Handshake outputs decode straight from registered state, so each valid
    // drops the cycle after its own handshake and never glitches on inputs.
    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RSP);
    assign m_axil.awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axil.wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axil.bready  = (state_q == WR_RESP);
    assign m_axil.arvalid = (state_q == RD_REQ);
    assign m_axil.rready  = (state_q == RD_DATA);

    // Payload comes only from capture registers: stable from accept until valid drops.
    assign m_axil.awaddr  = addr_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.awprot  = prot_q;
    assign m_axil.arprot  = prot_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;

    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;

    assign aw_hs = m_axil.awvalid & m_axil.awready;
    assign w_hs  = m_axil.wvalid & m_axil.wready;

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    prot_d    = cmd_prot;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid) begin
                    rsp_resp_d  = m_axil.bresp;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (m_axil.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil.rvalid) begin
                    rsp_resp_d  = m_axil.rresp;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axil.rdata;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             waiting;

    assign waiting     = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    assign timeout_err = timeout_err_q;

    // Counter restarts on every state change and saturates; the flag only
    // reports a stall, the FSM keeps waiting so the bus stays legal.
    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        if (!waiting || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Initiator end of the AXI4-Lite link: converts a simple single-beat command/response interface into AXI4-Lite master transactions on m_axil_* ports.
- Drives the slave-side DUT in the bench and in integration, as a register-access master.
- One transaction outstanding at a time.
- Obeys the handshake rules the slave-side checks enforce:
  - valid is held until ready;
  - payload is stable while valid;
  - valid drops the cycle after its handshake.

Parameters:
- ADDR_WIDTH, 16, address width of cmd_addr and m_axil_awaddr/araddr.
- DATA_WIDTH, 32, data width (32 or 64).
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write strobes.
- cmd_prot  in  3  AxPROT value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- m_axil_awaddr/awprot/awvalid out, awready in  AW channel.
- m_axil_wdata/wstrb/wvalid out, wready in  W channel.
- m_axil_bresp in[2], bvalid in, bready out  B channel.
- m_axil_araddr/arprot/arvalid out, arready in  AR channel.
- m_axil_rdata in, rresp in[2], rvalid in, rready out  R channel.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: all *valid, bready, rready, rsp_valid = 0; cmd_ready = 1 once out of reset; all payload registers = 0; state = IDLE.
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On cmd handshake, capture addr/data/strb/prot/write.
    - Write -> WR_REQ with awvalid=wvalid=1 next cycle.
    - Read -> RD_REQ with arvalid=1 next cycle.
  - WR_REQ:
    - AW and W complete independently; track aw_done and w_done flags.
    - Each valid deasserts the cycle after its own handshake.
    - Handshakes may occur in the same cycle or in either order.
    - When both are done (including the cycle of the last handshake) -> WR_RESP.
  - WR_RESP:
    - bready=1.
    - On bvalid: capture bresp, set rsp_write=1 and rsp_rdata=0, then -> RSP.
    - bvalid arriving before both AW and W complete is ignored (bready=0) until WR_RESP.
  - RD_REQ:
    - Hold arvalid until arready, then -> RD_DATA.
  - RD_DATA:
    - rready=1.
    - On rvalid: capture rdata/rresp, rsp_write=0, then -> RSP.
  - RSP:
    - rsp_valid=1, outputs stable, cmd_ready=0.
    - On rsp_ready -> IDLE; the next command can be accepted the cycle after.
- Payload stability: AW/W/AR payload comes from capture registers and is constant from the accept until the valid drops.
- Latency (all readies high): command accepted at cycle N -> AXI valid at N+1 -> bready/rready at N+2 -> rsp_valid at N+3. Minimum command-to-command spacing is 4 cycles.
- Any slave stall extends the current state indefinitely; there is no timeout unless the optional feature is enabled.
- cmd_valid while not in IDLE is ignored (cmd_ready=0).
- wstrb=0 writes are issued unchanged. Responses SLVERR/DECERR are forwarded, with no retry.
- Reset mid-operation: the next edge with rst=1 forces reset values. Valids drop even mid-handshake; the slave is reset by the same rst.

Optional Feature:
- Macro AXIL_MASTER_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT_CYCLES (default 256) is added.
  - Output timeout_err (1 bit) is added.
  - A counter resets on each state entry and counts while in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - At TIMEOUT_CYCLES, timeout_err is set sticky (cleared only by rst). The FSM keeps waiting, so protocol is never violated.
- When undefined: no counter and no port.

Decomposition:
- Package axil_pkg holds:
  - resp_e enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP);
  - default width constants.
- No sub-module: the FSM and capture registers are a single module, about 200 lines.

Test Plan:
- Write addr=16'h0010, data=32'hDEAD_BEEF, strb=4'hF, with slave readies always 1 -> awvalid/wvalid at N+1, bready at N+2, rsp_valid at N+3 with resp=OKAY and rsp_write=1.
- Write with awready delayed 5 cycles and wready immediate -> wvalid drops at N+2; awvalid and awaddr held stable through the stall; a single B handshake; rsp_valid only after bvalid.
- Read addr=16'h0020, slave returns rdata=32'h1234_5678 with rresp=SLVERR after a 3-cycle rvalid delay -> rsp_rdata=32'h1234_5678, rsp_resp=2'b10, rsp_write=0.
- Hold rsp_ready=0 for 4 cycles while cmd_valid=1 -> rsp outputs stable and cmd_ready=0; new command accepted the cycle after rsp_ready.
- Assert rst for 1 cycle during WR_REQ (awvalid=1) -> next cycle all valids=0, state IDLE, cmd_ready=1, no response emitted.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold arready=0 -> timeout_err=1 at count 16; arvalid remains 1 and stays sticky until rst.
